// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI mode-0 slave responder.
//   spi_slv_state_e : frame-level FSM state (IDLE / ACTIVE)
//   SPI_DATA_W      : default word width
//   SPI_FILL        : word sent on underrun when echo is disabled
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_FILL = '0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-flop synchronizer followed by a registered
// rise/fall detector. Each pulse is one clk wide and appears STAGES+1
// clk edges after the input changes at the pin.
// Ports:
//   clk, reset : system clock, async active-high reset
//   din        : asynchronous input
//   rise, fall : one-cycle edge pulses of the synchronized input
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev   <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev;
      fall   <= ~sync_q[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave transceiver, oversampled by clk.
// Receives MOSI words MSB first and returns response words on MISO in the
// same frame. Responses come from a one-entry holding register.
// Optional build macro: SPI_SLAVE_ECHO_EN -- when defined, an underrun
// sends the last completed rx_data instead of all zeros.
// Ports:
//   clk, reset          : system clock (>= 8x sclk), async active-high reset
//   sclk, mosi, start   : master-side inputs (start high for whole frame)
//   miso                : slave data out, 0 while idle
//   tx_data/valid/ready : holding register write handshake
//   rx_data, rx_valid   : last received word and its one-cycle strobe
//   tx_underrun         : strobe when a word loads from an empty holding reg
//   busy                : frame active
//
//   state  | meaning
//   IDLE   | no frame; miso held low, waiting for start rise
//   ACTIVE | frame in progress; shifting on sclk edges
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              start,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic sclk_rise, sclk_fall, start_rise, start_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_slv_state_e    state;
  logic [DATA_W-1:0] tx_shift, rx_shift, hold;
  logic              hold_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] fill_value, load_word;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_edge (
    .clk(clk), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_start_edge (
    .clk(clk), .reset(reset), .din(start), .rise(start_rise), .fall(start_fall)
  );

  // mosi only needs to be stable around the sclk rise pulse, so a plain
  // synchronizer is enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_ECHO_EN
  assign fill_value = rx_data;
`else
  assign fill_value = DATA_W'(SPI_FILL);
`endif

  assign load_word = hold_full ? hold : fill_value;
  assign tx_ready  = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
      busy        <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (start_rise) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= load_word;
            miso      <= load_word[DATA_W-1];
            hold_full <= 1'b0;
            if (!hold_full) tx_underrun <= 1'b1;
          end
        end

        ACTIVE: begin
          if (start_fall) begin
            // Partial word is dropped; nothing reaches rx_data.
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            miso    <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            if (bit_cnt == CNT_W'(DATA_W-1)) begin
              rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            // bit_cnt == 0 on a fall means the previous word just completed.
            if (bit_cnt == '0) begin
              tx_shift  <= load_word;
              miso      <= load_word[DATA_W-1];
              hold_full <= 1'b0;
              if (!hold_full) tx_underrun <= 1'b1;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              miso     <= tx_shift[DATA_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase

      // A write lands after any load in the same cycle, so it refills the
      // holding register rather than joining the word just loaded.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, mosi, start;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  spi_slave_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .start(start),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: observed strobes, sampled on the falling clk edge.
  logic [7:0] rxq[$];
  int under_cnt = 0;
  int acc_cnt   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid)            rxq.push_back(rx_data);
      if (tx_underrun)         under_cnt++;
      if (tx_valid && tx_ready) acc_cnt++;
    end
  end

  // Reference model: a word source with one optional held entry.
  logic [7:0] m_hold;
  bit         m_hold_v;
  logic [7:0] m_last_rx;
  int         m_under;

  task automatic model_load(output logic [7:0] w);
    if (m_hold_v) begin
      w = m_hold;
      m_hold_v = 0;
    end else begin
`ifdef SPI_SLAVE_ECHO_EN
      w = m_last_rx;
`else
      w = 8'h00;
`endif
      m_under++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] w);
    int n;
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    if (!tx_ready) check_val("wr_timeout", 32'(tx_ready), 32'(1));
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    m_hold   = w;
    m_hold_v = 1;
  endtask

  // Frame plan
  int         f_nb;
  logic [7:0] f_mosi[4];
  logic       f_wen[4];
  logic [7:0] f_wdat[4];
  logic       f_pre;
  logic [7:0] f_pre_w;
  logic       f_hold_through;
  logic [7:0] f_hold_b;

  task automatic do_frame();
    logic [7:0] exp_tx[5];
    logic [7:0] got;
    int base;
    base = rxq.size();
    if (f_pre) write_word(f_pre_w);
    start = 1'b1;
    model_load(exp_tx[0]);
    repeat (8) tick();
    if (f_hold_through) begin
      tx_valid = 1'b0;
      m_hold   = f_hold_b;
      m_hold_v = 1;
    end
    check_val("busy_act", 32'(busy), 32'(1));
    check_val("tx_ready_ld", 32'(tx_ready), 32'(!m_hold_v));
    for (int k = 0; k < f_nb; k++) begin
      got = '0;
      for (int b = 7; b >= 0; b--) begin
        mosi = f_mosi[k][b];
        if (b == 3 && f_wen[k]) write_word(f_wdat[k]);
        repeat (5) tick();
        got[b] = miso;
        sclk = 1'b1;
        repeat (5) tick();
        sclk = 1'b0;
      end
      check_val($sformatf("miso_b%0d", k), 32'(got), 32'(exp_tx[k]));
      m_last_rx = f_mosi[k];
      model_load(exp_tx[k+1]);
    end
    repeat (8) tick();
    start = 1'b0;
    repeat (8) tick();
    check_val("busy_idle", 32'(busy), 32'(0));
    check_val("miso_idle", 32'(miso), 32'(0));
    check_val("rx_count", 32'(rxq.size() - base), 32'(f_nb));
    for (int k = 0; k < f_nb && base + k < rxq.size(); k++)
      check_val($sformatf("rx_b%0d", k), 32'(rxq[base+k]), 32'(f_mosi[k]));
    check_val("rx_data_hold", 32'(rx_data), 32'(m_last_rx));
    check_val("underruns", 32'(under_cnt), 32'(m_under));
  endtask

  task automatic clear_plan();
    f_nb = 1; f_pre = 0; f_pre_w = 0; f_hold_through = 0; f_hold_b = 0;
    for (int k = 0; k < 4; k++) begin
      f_mosi[k] = 0; f_wen[k] = 0; f_wdat[k] = 0;
    end
  endtask

  task automatic abort_frame();
    logic [7:0] w;
    int base;
    base = rxq.size();
    start = 1'b1;
    model_load(w);
    repeat (8) tick();
    // five sclk edges: rise, fall, rise, fall, rise
    for (int e = 0; e < 5; e++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = (e % 2 == 0);
      repeat (5) tick();
    end
    start = 1'b0;
    repeat (2) tick();
    sclk = 1'b0;
    repeat (10) tick();
    check_val("abort_rx_count", 32'(rxq.size() - base), 32'(0));
    check_val("abort_rx_data", 32'(rx_data), 32'(m_last_rx));
    check_val("abort_busy", 32'(busy), 32'(0));
    check_val("abort_under", 32'(under_cnt), 32'(m_under));
  endtask

  int acc0;

  initial begin
    reset = 1'b1; sclk = 0; mosi = 0; start = 0; tx_data = 0; tx_valid = 0;
    m_hold = 0; m_hold_v = 0; m_last_rx = 0; m_under = 0;
    clear_plan();
    repeat (3) tick();
    check_val("rst_miso", 32'(miso), 32'(0));
    check_val("rst_rx_data", 32'(rx_data), 32'(0));
    check_val("rst_rx_valid", 32'(rx_valid), 32'(0));
    check_val("rst_underrun", 32'(tx_underrun), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_tx_ready", 32'(tx_ready), 32'(1));
    reset = 1'b0;
    repeat (3) tick();

    // Preloaded response, single word
    clear_plan(); f_pre = 1; f_pre_w = 8'hA5; f_mosi[0] = 8'h3C;
    do_frame();

    // No write: underrun at start, fill or echo
    clear_plan(); f_mosi[0] = 8'h55;
    do_frame();

    // Two words, second written after the first load
    clear_plan(); f_nb = 2; f_pre = 1; f_pre_w = 8'h81;
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22; f_wen[0] = 1; f_wdat[0] = 8'h7E;
    do_frame();

    // Aborted frame, then a full one
    abort_frame();
    clear_plan(); f_pre = 1; f_pre_w = 8'h96; f_mosi[0] = 8'hF0;
    do_frame();

    // tx_valid held high across a full holding register
    acc0 = acc_cnt;
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_data = 8'h4B;
    repeat (5) tick();
    check_val("held_not_ready", 32'(tx_ready), 32'(0));
    m_hold = 8'hC3; m_hold_v = 1;
    clear_plan(); f_nb = 2; f_mosi[0] = 8'h0F; f_mosi[1] = 8'hE1;
    f_hold_through = 1; f_hold_b = 8'h4B;
    do_frame();
    check_val("held_accepts", 32'(acc_cnt - acc0), 32'(2));

    // Randomized frames
    for (int r = 0; r < 12; r++) begin
      clear_plan();
      f_nb = $urandom_range(1, 3);
      f_pre = 1'($urandom_range(0, 1));
      f_pre_w = 8'($urandom);
      for (int k = 0; k < f_nb; k++) begin
        f_mosi[k] = 8'($urandom);
        f_wen[k]  = 1'($urandom_range(0, 1));
        f_wdat[k] = 8'($urandom);
      end
      do_frame();
    end

    // Reset in the middle of a frame with the holding register full
    write_word(8'h5A);
    write_word_skip: begin end
    start = 1'b1;
    repeat (8) tick();
    write_word(8'hA7);
    sclk = 1'b1; repeat (5) tick(); sclk = 1'b0; repeat (3) tick();
    reset = 1'b1;
    #1;
    check_val("mid_rst_miso", 32'(miso), 32'(0));
    check_val("mid_rst_rx_data", 32'(rx_data), 32'(0));
    check_val("mid_rst_rx_valid", 32'(rx_valid), 32'(0));
    check_val("mid_rst_underrun", 32'(tx_underrun), 32'(0));
    check_val("mid_rst_busy", 32'(busy), 32'(0));
    check_val("mid_rst_tx_ready", 32'(tx_ready), 32'(1));
    start = 1'b0; sclk = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_hold_v = 0; m_last_rx = 0;
    repeat (4) tick();
    check_val("post_rst_ready", 32'(tx_ready), 32'(1));

    // Frame after reset: held word was lost
    clear_plan(); f_mosi[0] = 8'h3D;
    do_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI mode-0 slave transceiver, system-clock oversampled.
- Receives MOSI bytes and returns response bytes on MISO in the same frame, so the MISO path now has a real driver.
- Sits beside the slave receive path: frame select `start` (active-high), `sclk` and `mosi` come from the master; `miso` goes back to the master.
- Parallel side uses a one-entry transmit holding register with valid/ready, plus a one-cycle receive strobe.

Parameters:
- DATA_W, 8: bits per SPI word, transferred MSB first.
- SYNC_STAGES, 2: synchronizer flops on `sclk`, `mosi` and `start`. Minimum 2.

Ports:
- clk  input  1  system clock; frequency must be at least 8x sclk.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master; idles low.
- mosi  input  1  master-out data.
- start  input  1  frame select; high for the whole frame.
- miso  output  1  slave-out data.
- tx_data  input  DATA_W  response word to send next.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  holding register empty; a write is accepted when tx_valid and tx_ready are both high.
- rx_data  output  DATA_W  last complete received word; held until the next completed word.
- rx_valid  output  1  one-cycle strobe when rx_data updates.
- tx_underrun  output  1  one-cycle strobe when a word loads with the holding register empty.
- busy  output  1  frame active (synchronized start high).

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, tx_ready=1. Reset also clears the shift registers, bit_cnt and the FSM.
- Input conditioning: SYNC_STAGES flops, then one more register for edge detection. This yields sclk_rise/sclk_fall and start_rise/start_fall pulses.
- FSM IDLE:
  - miso=0 while in IDLE.
  - On start_rise: load tx_shift, set bit_cnt=0, go to ACTIVE.
- FSM ACTIVE:
  - start_fall has priority over everything: go to IDLE, bit_cnt=0, partial rx discarded, no rx_valid.
  - miso = tx_shift[DATA_W-1].
  - sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++.
  - When bit_cnt == DATA_W-1 at sclk_rise: rx_data <= {rx_shift[DATA_W-2:0], mosi_s}, rx_valid=1 next cycle, bit_cnt wraps to 0.
  - sclk_fall with bit_cnt != 0: tx_shift shifts left, LSB filled with 0.
  - sclk_fall with bit_cnt == 0: this is a byte boundary, so load tx_shift instead of shifting. The first fall of a frame, before any rise, cannot occur in mode 0.
- Load rule, used at start_rise and at byte boundaries:
  - Holding full: tx_shift <= holding; holding emptied; tx_ready=1 next cycle.
  - Holding empty: tx_shift <= fill value; tx_underrun pulses.
  - A tx_valid arriving in the same cycle as a load goes into holding, not into the current load.
- Holding register: written on tx_valid && tx_ready; tx_ready=0 while full. Writes are allowed in IDLE.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the final sclk rising edge at the pin. miso updates SYNC_STAGES+2 clk cycles after the sclk falling edge (or start rising edge) at the pin.
- Simultaneous sclk_rise and start_fall: start_fall wins; no rx_valid.
- Back-to-back frames: a start_rise in the same cycle as the previous start_fall is impossible, because the synchronized start toggles at most once per cycle.
- Reset mid-frame: everything returns to reset values immediately; a word already held is lost.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: the fill value on underrun is the last completed rx_data, so the slave echoes. tx_underrun still pulses.
- Undefined: the fill value is all zeros.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic {IDLE, ACTIVE} spi_slv_state_e;
  - localparam SPI_DATA_W = 8;
  - localparam SPI_FILL = '0.
- One natural sub-module, spi_sync_edge: an N-stage synchronizer plus rise/fall detector. Instantiated for sclk and start; mosi uses the synchronizer output only.

Test Plan:
- Write 0xA5 while idle, then one frame with MOSI 0x3C (sclk = clk/10) -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with exactly one rx_valid; tx_ready back to 1 after load; no tx_underrun.
- Two-byte frame, holding 0x81 preloaded and 0x7E written after the first load, MOSI 0x11,0x22 -> MISO 0x81 then 0x7E; rx_valid twice (0x11, 0x22).
- Frame with no tx write, MOSI 0x55 -> tx_underrun at start_rise; MISO 0x00. With SPI_SLAVE_ECHO_EN after a prior rx of 0x3C -> MISO 0x3C.
- start drops after 5 sclk edges -> no rx_valid; rx_data keeps its previous value; the next full frame with 0xF0 receives 0xF0 correctly (bit_cnt restarted).
- reset pulsed mid-frame with holding full -> all outputs at reset values the same cycle; tx_ready=1.
- tx_valid held high while holding full -> a single write is accepted; the second value is accepted only after the next load.
